// File: rtl/chan_rd_sched.sv
// Readout scheduler: gathers per-channel hits into sticky pending flags, feeds them to
// the external priority encoder and runs a fixed-length word burst for the granted channel.
module chan_rd_sched #(
    parameter int SIZE       = 3,
    parameter int WORDS_LOG2 = 2,
    parameter int LOST_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**SIZE-1:0]    hit,
    input  logic [2**SIZE-1:0]    en_mask,
    output logic [2**SIZE-1:0]    req_vec,
    input  logic [SIZE-1:0]       enc_idx,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [SIZE-1:0]       rd_ch,
    output logic [WORDS_LOG2-1:0] rd_word,
    output logic                  frame_done,
    output logic                  busy,
    output logic [LOST_W-1:0]     lost_cnt,
    input  logic                  lost_clr
);

    localparam int N = 2**SIZE;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [WORDS_LOG2-1:0] LAST_WORD = '1;
    localparam logic [LOST_W-1:0]     LOST_MAX  = '1;

    logic [0:0]            state_q, state_d;
    logic [N-1:0]          pending_q, pending_d;
    logic [SIZE-1:0]       cur_ch_q, cur_ch_d;
    logic [WORDS_LOG2-1:0] word_cnt_q, word_cnt_d;
    logic                  frame_done_q, frame_done_d;
    logic [LOST_W-1:0]     lost_cnt_q, lost_cnt_d;

    logic [N-1:0]          set_vec;
    logic [N-1:0]          clr_vec;
    logic                  lost_hit;

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d      = state_q;
        cur_ch_d     = cur_ch_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        clr_vec      = '0;

        case (state_q)
            IDLE: begin
                // enc_idx is only meaningful while something is pending.
                if (pending_q != '0) begin
                    cur_ch_d         = enc_idx;
                    clr_vec[enc_idx] = 1'b1;
                    word_cnt_d       = '0;
                    state_d          = BURST;
                end
            end
            BURST: begin
                if (rd_ready) begin
                    if (word_cnt_q == LAST_WORD) begin
                        frame_done_d = 1'b1;
                        word_cnt_d   = '0;
                        state_d      = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + WORDS_LOG2'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clearing at grant lets a hit arriving during the burst re-arm the same channel.
    assign set_vec   = hit & en_mask;
    assign pending_d = ((pending_q & ~clr_vec) | set_vec) & en_mask;
    assign lost_hit  = |(set_vec & pending_q & ~clr_vec);

    always_comb begin
        lost_cnt_d = lost_cnt_q;
        if (lost_clr) begin
            lost_cnt_d = '0;
        end else if (lost_hit && (lost_cnt_q != LOST_MAX)) begin
            lost_cnt_d = lost_cnt_q + LOST_W'(1);
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            cur_ch_q     <= '0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            lost_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cur_ch_q     <= cur_ch_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
            lost_cnt_q   <= lost_cnt_d;
        end
    end

    assign req_vec    = pending_q;
    assign rd_valid   = (state_q == BURST);
    assign busy       = (state_q == BURST);
    assign rd_ch      = cur_ch_q;
    assign rd_word    = word_cnt_q;
    assign frame_done = frame_done_q;
    assign lost_cnt   = lost_cnt_q;

endmodule

// File: tb/tb_chan_rd_sched.sv
// Bench for chan_rd_sched: directed scenarios plus a randomized run checked against a
// cycle-level behavioural model of the scheduler; the bench itself acts as the encoder.
module tb_chan_rd_sched;

    localparam int SZ       = 3;
    localparam int WL       = 2;
    localparam int LW       = 4;
    localparam int N        = 2**SZ;
    localparam int WORDS    = 2**WL;
    localparam int LOST_MAX = 2**LW - 1;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  hit;
    logic [N-1:0]  en_mask;
    logic [N-1:0]  req_vec;
    logic [SZ-1:0] enc_idx;
    logic          rd_valid;
    logic          rd_ready;
    logic [SZ-1:0] rd_ch;
    logic [WL-1:0] rd_word;
    logic          frame_done;
    logic          busy;
    logic [LW-1:0] lost_cnt;
    logic          lost_clr;

    int checks = 0;
    int errors = 0;

    chan_rd_sched #(.SIZE(SZ), .WORDS_LOG2(WL), .LOST_W(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hit        (hit),
        .en_mask    (en_mask),
        .req_vec    (req_vec),
        .enc_idx    (enc_idx),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_ch      (rd_ch),
        .rd_word    (rd_word),
        .frame_done (frame_done),
        .busy       (busy),
        .lost_cnt   (lost_cnt),
        .lost_clr   (lost_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream priority encoder: lowest set index, 0 when nothing is requested.
    always_comb begin
        enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vec[i]) enc_idx = SZ'(i);
        end
    end

    // Behavioural model: channel being served (-1 = none), words already accepted,
    // pending set, lost total and the frame_done pulse visible after the last edge.
    logic [N-1:0] m_pend;
    int           m_ch;
    int           m_word;
    int           m_lost;
    logic         m_fd;

    task automatic model_reset();
        m_pend = '0;
        m_ch   = -1;
        m_word = 0;
        m_lost = 0;
        m_fd   = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] h, input logic [N-1:0] en,
                              input logic rdy, input logic clr);
        logic [N-1:0] granted;
        logic [N-1:0] lossy;
        int           next_ch;
        granted = '0;
        next_ch = m_ch;
        m_fd    = 1'b0;
        if (m_ch < 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (m_pend[i]) next_ch = i;
            end
            if (next_ch >= 0) begin
                granted[next_ch] = 1'b1;
                m_word = 0;
            end
        end else if (rdy) begin
            if (m_word == WORDS - 1) begin
                m_fd    = 1'b1;
                next_ch = -1;
                m_word  = 0;
            end else begin
                m_word++;
            end
        end
        lossy = h & en & m_pend & ~granted;
        if (clr) m_lost = 0;
        else if ((lossy != '0) && (m_lost < LOST_MAX)) m_lost++;
        m_pend = ((m_pend & ~granted) | (h & en)) & en;
        m_ch   = next_ch;
    endtask

    // Apply one cycle of inputs, advance past the edge and settle 1 time unit after it.
    task automatic tick(input logic [N-1:0] h, input logic [N-1:0] en,
                        input logic rdy, input logic clr);
        hit      = h;
        en_mask  = en;
        rd_ready = rdy;
        lost_clr = clr;
        @(posedge clk);
        model_step(h, en, rdy, clr);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        hit      = '0;
        en_mask  = '1;
        rd_ready = 1'b0;
        lost_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hit = '0; en_mask = '1; rd_ready = 1'b1; lost_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_vec, rd_valid, busy, frame_done, rd_ch, rd_word, lost_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: req=%h valid=%b busy=%b fd=%b ch=%0d word=%0d lost=%0d, all must be 0",
                     req_vec, rd_valid, busy, frame_done, rd_ch, rd_word, lost_cnt);
        end
        rst_n = 1'b1;
        model_reset();
        tick('0, '1, 1'b1, 1'b0);
        checks++;
        if ({req_vec, rd_valid, busy} !== '0) begin
            errors++;
            $display("FAIL reset_idle: req=%h valid=%b busy=%b expected 0/0/0", req_vec, rd_valid, busy);
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        tick(8'h10, '1, 1'b1, 1'b0);
        checks++;
        if (req_vec !== 8'h10 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pend: req=%h valid=%b expected 10/0", req_vec, rd_valid);
        end
        tick('0, '1, 1'b1, 1'b0);
        for (int w = 0; w < WORDS; w++) begin
            checks++;
            if ({rd_valid, busy, frame_done, rd_ch, rd_word} !== {1'b1, 1'b1, 1'b0, 3'd4, WL'(w)}) begin
                errors++;
                $display("FAIL single_word%0d: valid/busy/fd/ch/word=%b/%b/%b/%0d/%0d expected 1/1/0/4/%0d",
                         w, rd_valid, busy, frame_done, rd_ch, rd_word, w);
            end
            tick('0, '1, 1'b1, 1'b0);
        end
        checks++;
        if ({rd_valid, busy, frame_done} !== 3'b001) begin
            errors++;
            $display("FAIL single_done: valid/busy/fd=%b/%b/%b expected 0/0/1", rd_valid, busy, frame_done);
        end
        tick('0, '1, 1'b1, 1'b0);
        checks++;
        if ({rd_valid, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL single_after: valid/fd=%b/%b expected 0/0", rd_valid, frame_done);
        end
    endtask

    task automatic test_two_channels();
        do_reset();
        tick(8'h24, '1, 1'b1, 1'b0);
        checks++;
        if (req_vec !== 8'h24) begin
            errors++;
            $display("FAIL two_pend: req=%h expected 24", req_vec);
        end
        tick('0, '1, 1'b1, 1'b0);
        for (int w = 0; w < WORDS; w++) begin
            checks++;
            if ({rd_valid, rd_ch, rd_word, req_vec} !== {1'b1, 3'd2, WL'(w), 8'h20}) begin
                errors++;
                $display("FAIL two_ch2_word%0d: valid/ch/word/req=%b/%0d/%0d/%h expected 1/2/%0d/20",
                         w, rd_valid, rd_ch, rd_word, req_vec, w);
            end
            tick('0, '1, 1'b1, 1'b0);
        end
        checks++;
        if ({rd_valid, frame_done, req_vec} !== {1'b0, 1'b1, 8'h20}) begin
            errors++;
            $display("FAIL two_gap: valid/fd/req=%b/%b/%h expected 0/1/20", rd_valid, frame_done, req_vec);
        end
        tick('0, '1, 1'b1, 1'b0);
        for (int w = 0; w < WORDS; w++) begin
            checks++;
            if ({rd_valid, rd_ch, rd_word, req_vec} !== {1'b1, 3'd5, WL'(w), 8'h00}) begin
                errors++;
                $display("FAIL two_ch5_word%0d: valid/ch/word/req=%b/%0d/%0d/%h expected 1/5/%0d/00",
                         w, rd_valid, rd_ch, rd_word, req_vec, w);
            end
            tick('0, '1, 1'b1, 1'b0);
        end
        checks++;
        if ({rd_valid, frame_done, req_vec} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL two_end: valid/fd/req=%b/%b/%h expected 0/1/00", rd_valid, frame_done, req_vec);
        end
    endtask

    task automatic test_stall_rearm();
        int   w;
        logic rdy;
        do_reset();
        tick(8'h04, '1, 1'b0, 1'b0);
        tick('0, '1, 1'b0, 1'b0);
        w = 0;
        for (int c = 0; c < 40 && w < WORDS; c++) begin
            rdy = ((c % 3) == 0);
            checks++;
            if ({rd_valid, frame_done, rd_ch, rd_word} !== {1'b1, 1'b0, 3'd2, WL'(w)}) begin
                errors++;
                $display("FAIL stall_c%0d: valid/fd/ch/word=%b/%b/%0d/%0d expected 1/0/2/%0d",
                         c, rd_valid, frame_done, rd_ch, rd_word, w);
            end
            tick((c == 1) ? 8'h04 : 8'h00, '1, rdy, 1'b0);
            if (rdy) w++;
        end
        checks++;
        if ({rd_valid, frame_done, req_vec} !== {1'b0, 1'b1, 8'h04}) begin
            errors++;
            $display("FAIL stall_done: valid/fd/req=%b/%b/%h expected 0/1/04", rd_valid, frame_done, req_vec);
        end
        tick('0, '1, 1'b1, 1'b0);
        checks++;
        if ({rd_valid, rd_ch, rd_word, req_vec, lost_cnt} !== {1'b1, 3'd2, 2'd0, 8'h00, 4'd0}) begin
            errors++;
            $display("FAIL stall_reserve: valid/ch/word/req/lost=%b/%0d/%0d/%h/%0d expected 1/2/0/00/0",
                     rd_valid, rd_ch, rd_word, req_vec, lost_cnt);
        end
        repeat (WORDS) tick('0, '1, 1'b1, 1'b0);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_reserve_done: fd=%b expected 1", frame_done);
        end
    endtask

    task automatic test_lost_hits();
        do_reset();
        tick(8'h01, '1, 1'b0, 1'b0);
        tick('0, '1, 1'b0, 1'b0);
        tick(8'h02, '1, 1'b0, 1'b0);
        checks++;
        if ({lost_cnt, req_vec, rd_ch, rd_valid} !== {4'd0, 8'h02, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL lost_first: lost/req/ch/valid=%0d/%h/%0d/%b expected 0/02/0/1",
                     lost_cnt, req_vec, rd_ch, rd_valid);
        end
        repeat (3) tick(8'h02, '1, 1'b0, 1'b0);
        checks++;
        if (lost_cnt !== 4'd3) begin
            errors++;
            $display("FAIL lost_three: lost=%0d expected 3", lost_cnt);
        end
        tick('0, '1, 1'b0, 1'b1);
        checks++;
        if (lost_cnt !== 4'd0) begin
            errors++;
            $display("FAIL lost_clear: lost=%0d expected 0", lost_cnt);
        end
        tick(8'h02, '1, 1'b0, 1'b1);
        checks++;
        if (lost_cnt !== 4'd0) begin
            errors++;
            $display("FAIL lost_clear_prio: lost=%0d expected 0", lost_cnt);
        end
        tick(8'h03, '1, 1'b0, 1'b0);
        checks++;
        if (lost_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lost_one_per_cycle: lost=%0d expected 1", lost_cnt);
        end
        repeat (LOST_MAX + 5) tick(8'h02, '1, 1'b0, 1'b0);
        checks++;
        if (lost_cnt !== 4'(LOST_MAX)) begin
            errors++;
            $display("FAIL lost_saturate: lost=%0d expected %0d", lost_cnt, LOST_MAX);
        end
        tick(8'h02, '1, 1'b0, 1'b0);
        checks++;
        if (lost_cnt !== 4'(LOST_MAX)) begin
            errors++;
            $display("FAIL lost_hold_sat: lost=%0d expected %0d", lost_cnt, LOST_MAX);
        end
    endtask

    task automatic test_mask();
        do_reset();
        tick(8'h01, 8'hFE, 1'b1, 1'b0);
        checks++;
        if (req_vec !== 8'h00) begin
            errors++;
            $display("FAIL mask_ignore: req=%h expected 00", req_vec);
        end
        tick('0, 8'hFE, 1'b1, 1'b0);
        checks++;
        if ({rd_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL mask_noburst: valid/busy=%b/%b expected 0/0", rd_valid, busy);
        end
        tick(8'h01, '1, 1'b0, 1'b0);
        tick(8'h08, '1, 1'b0, 1'b0);
        checks++;
        if ({req_vec, rd_valid, rd_ch} !== {8'h08, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL mask_ch3_pend: req/valid/ch=%h/%b/%0d expected 08/1/0", req_vec, rd_valid, rd_ch);
        end
        tick('0, 8'hF6, 1'b0, 1'b0);
        checks++;
        if ({req_vec, rd_valid} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL mask_drop: req/valid=%h/%b expected 00/1", req_vec, rd_valid);
        end
        for (int w = 0; w < WORDS; w++) begin
            checks++;
            if ({rd_valid, rd_ch, rd_word} !== {1'b1, 3'd0, WL'(w)}) begin
                errors++;
                $display("FAIL mask_cur_word%0d: valid/ch/word=%b/%0d/%0d expected 1/0/%0d",
                         w, rd_valid, rd_ch, rd_word, w);
            end
            tick('0, 8'hF6, 1'b1, 1'b0);
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL mask_cur_done: fd=%b expected 1", frame_done);
        end
        for (int c = 0; c < 3; c++) begin
            tick('0, 8'hF6, 1'b1, 1'b0);
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL mask_idle%0d: valid=%b expected 0", c, rd_valid);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        tick(8'h03, '1, 1'b1, 1'b0);
        tick('0, '1, 1'b1, 1'b0);
        tick(8'h02, '1, 1'b1, 1'b0);
        tick('0, '1, 1'b1, 1'b0);
        checks++;
        if ({rd_valid, rd_word, lost_cnt, req_vec} !== {1'b1, 2'd2, 4'd1, 8'h02}) begin
            errors++;
            $display("FAIL rstmid_pre: valid/word/lost/req=%b/%0d/%0d/%h expected 1/2/1/02",
                     rd_valid, rd_word, lost_cnt, req_vec);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_vec, rd_valid, busy, frame_done, rd_ch, rd_word, lost_cnt} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: req=%h valid=%b busy=%b fd=%b ch=%0d word=%0d lost=%0d, all must be 0",
                     req_vec, rd_valid, busy, frame_done, rd_ch, rd_word, lost_cnt);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({frame_done, rd_valid} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_hold%0d: fd/valid=%b/%b expected 0/0", c, frame_done, rd_valid);
            end
        end
        rst_n = 1'b1;
        model_reset();
        tick('0, '1, 1'b1, 1'b0);
        checks++;
        if ({frame_done, rd_valid, req_vec} !== {1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rstmid_after: fd/valid/req=%b/%b/%h expected 0/0/00", frame_done, rd_valid, req_vec);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] h;
        logic [N-1:0] en;
        logic         rdy;
        logic         clr;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) h[i] = ($urandom_range(0, 5) == 0);
            en  = ($urandom_range(0, 9) == 0) ? N'($urandom) : '1;
            rdy = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 49) == 0);
            tick(h, en, rdy, clr);
            checks++;
            if (req_vec !== m_pend) begin
                errors++;
                $display("FAIL rand_req c%0d: got %h expected %h", c, req_vec, m_pend);
            end
            checks++;
            if ({rd_valid, busy} !== {2{m_ch >= 0}}) begin
                errors++;
                $display("FAIL rand_valid c%0d: valid/busy=%b/%b expected %0b", c, rd_valid, busy, m_ch >= 0);
            end
            checks++;
            if (frame_done !== m_fd) begin
                errors++;
                $display("FAIL rand_fd c%0d: got %b expected %b", c, frame_done, m_fd);
            end
            checks++;
            if (lost_cnt !== LW'(m_lost)) begin
                errors++;
                $display("FAIL rand_lost c%0d: got %0d expected %0d", c, lost_cnt, m_lost);
            end
            if (m_ch >= 0) begin
                checks++;
                if ({rd_ch, rd_word} !== {SZ'(m_ch), WL'(m_word)}) begin
                    errors++;
                    $display("FAIL rand_chword c%0d: ch/word=%0d/%0d expected %0d/%0d",
                             c, rd_ch, rd_word, m_ch, m_word);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_two_channels();
        test_stall_rearm();
        test_lost_hits();
        test_mask();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
